// File: rtl/alu_op_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : alu_op_sequencer
//  Description : Issuing side of an ALU function-select interface. Accepts
//                SINGLE / MUL requests over valid/ready, drives registered
//                ALU operands and FS codes, and returns result, zero flag and
//                error over a held valid/ready response channel.
//                Optional feature macro: ALU_SEQ_MUL_EN (enables the
//                shift-add MUL sequence; otherwise op 01 is illegal).
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_op_sequencer #(
    parameter int         WIDTH   = 16,
    parameter logic [3:0] IDLE_FS = 4'b1011
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [3:0]       req_fs,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_fs,
    input  logic [WIDTH-1:0] alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_z,
    output logic             rsp_err
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SINGLE    = 3'd1;
    localparam logic [2:0] S_DONE      = 3'd4;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [2:0] S_MUL_ADD   = 3'd2;
    localparam logic [2:0] S_MUL_SHIFT = 3'd3;
    localparam logic [3:0] FS_ADD      = 4'b0000;
    localparam logic [3:0] FS_SHL      = 4'b0110;
    localparam int         CW          = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
`endif

    logic [2:0]       state_q,    state_d;
    logic [WIDTH-1:0] alu_a_q,    alu_a_d;
    logic [WIDTH-1:0] alu_b_q,    alu_b_d;
    logic [3:0]       alu_fs_q,   alu_fs_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_z_q,    rsp_z_d;
    logic             rsp_err_q,  rsp_err_d;
`ifdef ALU_SEQ_MUL_EN
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mc_q,  mc_d;
    logic [WIDTH-1:0] mp_q,  mp_d;
    logic [CW-1:0]    cnt_q, cnt_d;
`endif

    // Next-state logic: ALU drive values are computed for the state being entered
    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_fs_d   = alu_fs_q;
        rsp_data_d = rsp_data_q;
        rsp_z_d    = rsp_z_q;
        rsp_err_d  = rsp_err_q;
`ifdef ALU_SEQ_MUL_EN
        acc_d      = acc_q;
        mc_d       = mc_q;
        mp_d       = mp_q;
        cnt_d      = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                alu_fs_d = IDLE_FS;
                if (req_valid) begin
                    case (req_op)
                        2'b00: begin
                            state_d  = S_SINGLE;
                            alu_a_d  = req_a;
                            alu_b_d  = req_b;
                            alu_fs_d = req_fs;
                        end
`ifdef ALU_SEQ_MUL_EN
                        2'b01: begin
                            acc_d = '0;
                            mc_d  = req_a;
                            mp_d  = req_b;
                            cnt_d = CNT_INIT;
                            if (req_b[0]) begin
                                state_d  = S_MUL_ADD;
                                alu_a_d  = '0;
                                alu_b_d  = req_a;
                                alu_fs_d = FS_ADD;
                            end else begin
                                state_d  = S_MUL_SHIFT;
                                alu_a_d  = req_a;
                                alu_b_d  = '0;
                                alu_fs_d = FS_SHL;
                            end
                        end
`endif
                        default: begin
                            state_d    = S_DONE;
                            rsp_data_d = '0;
                            rsp_z_d    = 1'b1;
                            rsp_err_d  = 1'b1;
                        end
                    endcase
                end
            end
            S_SINGLE: begin
                state_d    = S_DONE;
                rsp_data_d = alu_result;
                rsp_z_d    = (alu_result == '0);
                rsp_err_d  = 1'b0;
                alu_fs_d   = IDLE_FS;
            end
`ifdef ALU_SEQ_MUL_EN
            S_MUL_ADD: begin
                acc_d    = alu_result;
                state_d  = S_MUL_SHIFT;
                alu_a_d  = mc_q;
                alu_b_d  = '0;
                alu_fs_d = FS_SHL;
            end
            S_MUL_SHIFT: begin
                mc_d  = alu_result;
                mp_d  = mp_q >> 1;
                cnt_d = cnt_q - CW'(1);
                if (mp_d == '0 || cnt_d == '0) begin
                    // Shift steps never touch acc, so acc_q is the final product
                    state_d    = S_DONE;
                    rsp_data_d = acc_q;
                    rsp_z_d    = (acc_q == '0);
                    rsp_err_d  = 1'b0;
                    alu_fs_d   = IDLE_FS;
                end else if (mp_d[0]) begin
                    state_d  = S_MUL_ADD;
                    alu_a_d  = acc_q;
                    alu_b_d  = mc_d;
                    alu_fs_d = FS_ADD;
                end else begin
                    state_d  = S_MUL_SHIFT;
                    alu_a_d  = mc_d;
                    alu_b_d  = '0;
                    alu_fs_d = FS_SHL;
                end
            end
`endif
            S_DONE: begin
                alu_fs_d = IDLE_FS;
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d  = S_IDLE;
                alu_fs_d = IDLE_FS;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_fs_q   <= IDLE_FS;
            rsp_data_q <= '0;
            rsp_z_q    <= 1'b0;
            rsp_err_q  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            acc_q      <= '0;
            mc_q       <= '0;
            mp_q       <= '0;
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_fs_q   <= alu_fs_d;
            rsp_data_q <= rsp_data_d;
            rsp_z_q    <= rsp_z_d;
            rsp_err_q  <= rsp_err_d;
`ifdef ALU_SEQ_MUL_EN
            acc_q      <= acc_d;
            mc_q       <= mc_d;
            mp_q       <= mp_d;
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_DONE);
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_fs    = alu_fs_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_z     = rsp_z_q;
    assign rsp_err   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_alu_op_sequencer
//  Description : Directed self-checking bench for alu_op_sequencer with a
//                small behavioural ALU (0000 add, 0001 sub, 0110 shl A,
//                1011 pass A).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [3:0]  req_fs;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_fs;
    logic [15:0] alu_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_z;
    logic        rsp_err;

    int n_checks = 0;
    int n_errors = 0;

    alu_op_sequencer #(
        .WIDTH   (16),
        .IDLE_FS (4'b1011)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_fs     (req_fs),
        .req_a      (req_a),
        .req_b      (req_b),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_fs     (alu_fs),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_z      (rsp_z),
        .rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU
    always_comb begin
        case (alu_fs)
            4'b0000: alu_result = alu_a + alu_b;
            4'b0001: alu_result = alu_a - alu_b;
            4'b0110: alu_result = alu_a << 1;
            4'b1011: alu_result = alu_a;
            default: alu_result = alu_a ^ alu_b;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [3:0] fs,
                         input logic [15:0] a, input logic [15:0] b);
        req_valid = 1'b1;
        req_op    = op;
        req_fs    = fs;
        req_a     = a;
        req_b     = b;
        tick();
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_fs    = 4'b0000;
        req_a     = 16'h0;
        req_b     = 16'h0;
    endtask

    task automatic consume(input string tag);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({tag, "_valid_drop"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_ready_back"}, {31'd0, req_ready}, 32'd1);
    endtask

    // Bounded wait for rsp_valid; returns the number of cycles waited
    task automatic wait_rsp(input string tag, output int cycles);
        cycles = 0;
        while (!rsp_valid && cycles < 60) begin
            tick();
            cycles++;
        end
        if (!rsp_valid) begin
            chk({tag, "_timeout"}, {31'd0, rsp_valid}, 32'd1);
        end
    endtask

`ifdef ALU_SEQ_MUL_EN
    logic [3:0] exp_seq [5];
    logic [3:0] got_seq [8];
    int         nseq;
    int         ncyc;
`endif

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_fs    = 4'b0000;
        req_a     = 16'h0;
        req_b     = 16'h0;
        rsp_ready = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data",  {16'd0, rsp_data},  32'd0);
        chk("rst_rsp_z",     {31'd0, rsp_z},     32'd0);
        chk("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
        chk("rst_alu_a",     {16'd0, alu_a},     32'd0);
        chk("rst_alu_b",     {16'd0, alu_b},     32'd0);
        chk("rst_alu_fs",    {28'd0, alu_fs},    32'hB);
        rst = 1'b0;
        tick();

        // SINGLE add 7 + 9
        issue(2'b00, 4'b0000, 16'd7, 16'd9);
        chk("add_alu_fs",    {28'd0, alu_fs},    32'h0);
        chk("add_alu_a",     {16'd0, alu_a},     32'd7);
        chk("add_alu_b",     {16'd0, alu_b},     32'd9);
        chk("add_not_yet",   {31'd0, rsp_valid}, 32'd0);
        chk("add_busy",      {31'd0, req_ready}, 32'd0);
        tick();
        chk("add_valid",     {31'd0, rsp_valid}, 32'd1);
        chk("add_data",      {16'd0, rsp_data},  32'd16);
        chk("add_z",         {31'd0, rsp_z},     32'd0);
        chk("add_err",       {31'd0, rsp_err},   32'd0);
        chk("add_done_fs",   {28'd0, alu_fs},    32'hB);
        chk("add_done_busy", {31'd0, req_ready}, 32'd0);
        consume("add");

        // SINGLE sub 5 - 5, response held for 3 cycles; a request during DONE is ignored
        issue(2'b00, 4'b0001, 16'd5, 16'd5);
        tick();
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_fs    = 4'b0000;
        req_a     = 16'd1;
        req_b     = 16'd1;
        for (int i = 0; i < 3; i++) begin
            chk("sub_hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("sub_hold_data",  {16'd0, rsp_data},  32'd0);
            chk("sub_hold_z",     {31'd0, rsp_z},     32'd1);
            chk("sub_hold_err",   {31'd0, rsp_err},   32'd0);
            chk("sub_hold_fs",    {28'd0, alu_fs},    32'hB);
            tick();
        end
        req_valid = 1'b0;
        consume("sub");
        chk("sub_no_extra_accept", {31'd0, rsp_valid}, 32'd0);

`ifdef ALU_SEQ_MUL_EN
        // MUL 3 * 5: FS sequence add, shl, shl, add, shl
        exp_seq[0] = 4'b0000;
        exp_seq[1] = 4'b0110;
        exp_seq[2] = 4'b0110;
        exp_seq[3] = 4'b0000;
        exp_seq[4] = 4'b0110;
        issue(2'b01, 4'b0000, 16'd3, 16'd5);
        nseq = 0;
        while (!rsp_valid && nseq < 8) begin
            got_seq[nseq] = alu_fs;
            nseq++;
            tick();
        end
        chk("mul35_len", nseq, 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk("mul35_fs", {28'd0, got_seq[i]}, {28'd0, exp_seq[i]});
        end
        chk("mul35_valid", {31'd0, rsp_valid}, 32'd1);
        chk("mul35_data",  {16'd0, rsp_data},  32'd15);
        chk("mul35_z",     {31'd0, rsp_z},     32'd0);
        chk("mul35_err",   {31'd0, rsp_err},   32'd0);
        consume("mul35");

        // MUL 0x8000 * 2 wraps to zero
        issue(2'b01, 4'b0000, 16'h8000, 16'd2);
        wait_rsp("mulwrap", ncyc);
        chk("mulwrap_data", {16'd0, rsp_data}, 32'd0);
        chk("mulwrap_z",    {31'd0, rsp_z},    32'd1);
        chk("mulwrap_err",  {31'd0, rsp_err},  32'd0);
        consume("mulwrap");

        // MUL 9 * 0: a single shift step then DONE
        issue(2'b01, 4'b0000, 16'd9, 16'd0);
        chk("mul0_fs",    {28'd0, alu_fs},    32'h6);
        chk("mul0_busy",  {31'd0, rsp_valid}, 32'd0);
        tick();
        chk("mul0_valid", {31'd0, rsp_valid}, 32'd1);
        chk("mul0_data",  {16'd0, rsp_data},  32'd0);
        chk("mul0_z",     {31'd0, rsp_z},     32'd1);
        consume("mul0");
`else
        // MUL not built: op 01 is illegal and goes straight to DONE
        issue(2'b01, 4'b0000, 16'd3, 16'd5);
        chk("nomul_valid", {31'd0, rsp_valid}, 32'd1);
        chk("nomul_err",   {31'd0, rsp_err},   32'd1);
        chk("nomul_data",  {16'd0, rsp_data},  32'd0);
        chk("nomul_z",     {31'd0, rsp_z},     32'd1);
        consume("nomul");
`endif

        // Illegal op 11 goes straight to DONE
        issue(2'b11, 4'b0000, 16'd1, 16'd1);
        chk("ill_valid", {31'd0, rsp_valid}, 32'd1);
        chk("ill_err",   {31'd0, rsp_err},   32'd1);
        chk("ill_data",  {16'd0, rsp_data},  32'd0);
        chk("ill_z",     {31'd0, rsp_z},     32'd1);
        chk("ill_fs",    {28'd0, alu_fs},    32'hB);
        consume("ill");

        // A SINGLE after an error clears the error flag
        issue(2'b00, 4'b0000, 16'd2, 16'd3);
        tick();
        chk("clr_data", {16'd0, rsp_data}, 32'd5);
        chk("clr_err",  {31'd0, rsp_err},  32'd0);
        consume("clr");

        // Reset in the middle of an operation aborts without a response
`ifdef ALU_SEQ_MUL_EN
        issue(2'b01, 4'b0000, 16'd3, 16'd5);
        tick();
`else
        issue(2'b00, 4'b0000, 16'd3, 16'd5);
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_ready", {31'd0, req_ready}, 32'd1);
        chk("abort_fs",    {28'd0, alu_fs},    32'hB);
        chk("abort_data",  {16'd0, rsp_data},  32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
